ysyx_22050550_div: RTL and testbench

- Iterative radix-2 restoring integer divider for the EXU, the inverse-operation partner of the Booth multiplier.
- Uses the same EXU handshake as the multiplier: Valid/Ready/Flush in, one-cycle OutValid pulse out.
- Covers RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Returns quotient and remainder together; the EXU selects between them.

---
 rtl/ysyx_22050550_div.sv | 230 +++++++++++++++++++++++
 tb/tb_ysyx_22050550_div.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050550_div.sv
// ysyx_22050550_div: iterative radix-2 restoring integer divider for the EXU.
// Handles RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
// The divider computes one quotient bit per Busy cycle on operand magnitudes.
// A registered fix-up step then applies signs, word sign-extension and the
// divide-by-zero / signed-overflow results.
// Optional build macro: DIV_EARLY_OUT_EN. When it is defined, divide-by-zero
// and signed-overflow requests bypass the Busy iterations.
module ysyx_22050550_div #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_Exu_DivValid,
    input  logic            io_Exu_Flush,
    input  logic            io_Exu_Divw,
    input  logic            io_Exu_DivSigned,
    input  logic [XLEN-1:0] io_Exu_Dividend,
    input  logic [XLEN-1:0] io_Exu_Divisor,
    output logic            io_Exu_DivReady,
    output logic            io_Exu_OutValid,
    output logic [XLEN-1:0] io_Exu_Quotient,
    output logic [XLEN-1:0] io_Exu_Remainder
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [HALF-1:0] MIN_H = {1'b1, {(HALF-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            divw_q, divw_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] orig_q, orig_d;     // dividend in the active width, sign-extended for word ops
    logic [XLEN-1:0] rem_q, rem_d;       // partial remainder
    logic [XLEN-1:0] dvd_q, dvd_d;       // dividend magnitude shifting out, quotient bits shifting in
    logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] remo_q, remo_d;
    logic            outv_q, outv_d;
`ifdef DIV_EARLY_OUT_EN
    logic            early_q, early_d;
`endif

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_orig;
    logic            a_neg, b_neg, in_div0, in_ovf;

    // Condition the request operands: width extension, sign capture, magnitudes, special cases
    always_comb begin
        a_ext   = io_Exu_Divw ? {{HALF{io_Exu_DivSigned & io_Exu_Dividend[HALF-1]}}, io_Exu_Dividend[HALF-1:0]}
                              : io_Exu_Dividend;
        b_ext   = io_Exu_Divw ? {{HALF{io_Exu_DivSigned & io_Exu_Divisor[HALF-1]}}, io_Exu_Divisor[HALF-1:0]}
                              : io_Exu_Divisor;
        a_neg   = io_Exu_DivSigned & a_ext[XLEN-1];
        b_neg   = io_Exu_DivSigned & b_ext[XLEN-1];
        a_abs   = a_neg ? -a_ext : a_ext;
        b_abs   = b_neg ? -b_ext : b_ext;
        // Word results always sign-extend bit 31, even for the unsigned word forms
        a_orig  = io_Exu_Divw ? {{HALF{io_Exu_Dividend[HALF-1]}}, io_Exu_Dividend[HALF-1:0]}
                              : io_Exu_Dividend;
        in_div0 = io_Exu_Divw ? (io_Exu_Divisor[HALF-1:0] == '0) : (io_Exu_Divisor == '0);
        in_ovf  = io_Exu_DivSigned &
                  (io_Exu_Divw ? ((io_Exu_Dividend[HALF-1:0] == MIN_H) && (io_Exu_Divisor[HALF-1:0] == '1))
                               : ((io_Exu_Dividend == MIN_X) && (io_Exu_Divisor == '1)));
    end

    logic [XLEN:0]   shifted;
    logic            trial_ok;
    logic [XLEN-1:0] rem_step, dvd_step;

    // One restoring iteration: shift, trial-subtract, keep or restore
    always_comb begin
        shifted  = {rem_q, dvd_q[XLEN-1]};
        trial_ok = (shifted >= {1'b0, dvs_q});
        // When the trial succeeds the difference is below the divisor, so XLEN bits suffice
        rem_step = trial_ok ? (shifted[XLEN-1:0] - dvs_q) : shifted[XLEN-1:0];
        dvd_step = {dvd_q[XLEN-2:0], trial_ok};
    end

    logic [XLEN-1:0] q_mag, q_sgn, r_sgn, q_fin, r_fin;

    // Final result fix-up from the last iteration's magnitudes
    always_comb begin
        q_mag = divw_q ? {{HALF{1'b0}}, dvd_step[HALF-1:0]} : dvd_step;
        // a_neg_q/b_neg_q are only ever set for signed ops
        q_sgn = (a_neg_q ^ b_neg_q) ? -q_mag : q_mag;
        r_sgn = a_neg_q ? -rem_step : rem_step;
        if (divw_q) begin
            q_fin = {{HALF{q_sgn[HALF-1]}}, q_sgn[HALF-1:0]};
            r_fin = {{HALF{r_sgn[HALF-1]}}, r_sgn[HALF-1:0]};
        end else begin
            q_fin = q_sgn;
            r_fin = r_sgn;
        end
        if (div0_q) begin
            q_fin = '1;
            r_fin = orig_q;
        end else if (ovf_q) begin
            q_fin = orig_q;
            r_fin = '0;
        end
    end

    // Next-state logic for the Idle/Busy/Valid controller and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        divw_d  = divw_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        orig_d  = orig_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        outv_d  = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        early_d = early_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io_Exu_DivValid) begin
                    state_d = S_BUSY;
                    divw_d  = io_Exu_Divw;
                    a_neg_d = a_neg;
                    b_neg_d = b_neg;
                    div0_d  = in_div0;
                    ovf_d   = in_ovf;
                    orig_d  = a_orig;
                    rem_d   = '0;
                    // Word magnitudes start in the upper half so 32 shifts consume them
                    dvd_d   = io_Exu_Divw ? {a_abs[HALF-1:0], {HALF{1'b0}}} : a_abs;
                    dvs_d   = b_abs;
                    cnt_d   = io_Exu_Divw ? CW'(HALF) : CW'(XLEN);
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        state_d = S_VALID;
                        early_d = 1'b1;
                    end
`endif
                end
            end
            S_BUSY: begin
                if (io_Exu_Flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = dvd_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_VALID;
                        outv_d  = 1'b1;
                        quot_d  = q_fin;
                        remo_d  = r_fin;
                    end
                end
            end
            S_VALID: begin
                state_d = S_IDLE;
`ifdef DIV_EARLY_OUT_EN
                // Early-out results depend only on latched flags, so they register here
                if (early_q) begin
                    early_d = 1'b0;
                    outv_d  = 1'b1;
                    quot_d  = q_fin;
                    remo_d  = r_fin;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            divw_q  <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
            orig_q  <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            outv_q  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divw_q  <= divw_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            orig_q  <= orig_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            outv_q  <= outv_d;
`ifdef DIV_EARLY_OUT_EN
            early_q <= early_d;
`endif
        end
    end

    assign io_Exu_DivReady  = (state_q == S_IDLE);
    assign io_Exu_OutValid  = outv_q;
    assign io_Exu_Quotient  = quot_q;
    assign io_Exu_Remainder = remo_q;

endmodule

// File: tb/tb_ysyx_22050550_div.sv
// Scoreboard testbench for ysyx_22050550_div: directed cases plus randomized
// operands checked against a plain-arithmetic RISC-V division model.
module tb_ysyx_22050550_div;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_Exu_DivValid;
    logic        io_Exu_Flush;
    logic        io_Exu_Divw;
    logic        io_Exu_DivSigned;
    logic [63:0] io_Exu_Dividend;
    logic [63:0] io_Exu_Divisor;
    logic        io_Exu_DivReady;
    logic        io_Exu_OutValid;
    logic [63:0] io_Exu_Quotient;
    logic [63:0] io_Exu_Remainder;

    ysyx_22050550_div #(.XLEN(64)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_Exu_DivValid  (io_Exu_DivValid),
        .io_Exu_Flush     (io_Exu_Flush),
        .io_Exu_Divw      (io_Exu_Divw),
        .io_Exu_DivSigned (io_Exu_DivSigned),
        .io_Exu_Dividend  (io_Exu_Dividend),
        .io_Exu_Divisor   (io_Exu_Divisor),
        .io_Exu_DivReady  (io_Exu_DivReady),
        .io_Exu_OutValid  (io_Exu_OutValid),
        .io_Exu_Quotient  (io_Exu_Quotient),
        .io_Exu_Remainder (io_Exu_Remainder)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [63:0] last_q   = 64'd0;
    logic [63:0] last_r   = 64'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M-extension division semantics with plain arithmetic
    function automatic void model(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit special);
        longint      sa, sbv;
        int          sa32, sb32;
        logic [31:0] a32, b32, q32, r32;
        special = 1'b0;
        if (!w) begin
            if (b == 64'd0) begin
                q = '1; r = a; special = 1'b1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a; r = 64'd0; special = 1'b1;
            end else if (s) begin
                sa = a; sbv = b;
                q = 64'(sa / sbv); r = 64'(sa % sbv);
            end else begin
                q = a / b; r = a % b;
            end
        end else begin
            a32 = a[31:0]; b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; special = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; special = 1'b1;
            end else if (s) begin
                sa32 = a32; sb32 = b32;
                q32 = 32'(sa32 / sb32); r32 = 32'(sa32 % sb32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end
    endfunction

    // Monitor: every OutValid pops one expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && io_Exu_OutValid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_outvalid: got OutValid=1 with no request pending, required 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, " quotient"}, io_Exu_Quotient, e.q);
                    chk({e.name, " remainder"}, io_Exu_Remainder, e.r);
                    chk({e.name, " latency"}, 64'(cyc - e.acc), 64'(e.lat));
                    $display("txn %s q=0x%h r=0x%h lat=%0d", e.name, io_Exu_Quotient, io_Exu_Remainder, cyc - e.acc);
                    last_q = e.q;
                    last_r = e.r;
                end
            end
        end
    end

    // Present one request; called at a negedge, returns at the negedge after acceptance
    task automatic issue(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b,
                         input bit expect_res, input string nm);
        exp_t        e;
        logic [63:0] q, r;
        bit          special;
        int          n;
        n = 0;
        while (io_Exu_DivReady !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s ready_timeout: got DivReady=0 for 200 cycles, required 1", nm);
        end
        io_Exu_Divw      = w;
        io_Exu_DivSigned = s;
        io_Exu_Dividend  = a;
        io_Exu_Divisor   = b;
        io_Exu_DivValid  = 1'b1;
        if (expect_res) begin
            model(w, s, a, b, q, r, special);
            e.q    = q;
            e.r    = r;
            e.acc  = cyc;
            e.lat  = w ? 33 : 65;
`ifdef DIV_EARLY_OUT_EN
            if (special) e.lat = 2;
`endif
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clock);
        io_Exu_DivValid  = 1'b0;
        io_Exu_Dividend  = {$urandom, $urandom};
        io_Exu_Divisor   = {$urandom, $urandom};
        io_Exu_Divw      = 1'($urandom_range(0, 1));
        io_Exu_DivSigned = 1'($urandom_range(0, 1));
    endtask

    // Wait for the result strobe, checking DivReady stays low meanwhile
    task automatic wait_done(input string nm);
        int n;
        bit ready_hi;
        n = 0;
        ready_hi = 1'b0;
        while (io_Exu_OutValid !== 1'b1 && n < 200) begin
            if (io_Exu_DivReady === 1'b1) ready_hi = 1'b1;
            @(negedge clock);
            n++;
        end
        chk({nm, " outvalid_seen"}, {63'd0, io_Exu_OutValid}, 64'd1);
        chk({nm, " ready_low"}, {63'd0, ready_hi}, 64'd0);
    endtask

    task automatic run(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b, input string nm);
        issue(w, s, a, b, 1'b1, nm);
        wait_done(nm);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'hFFFF_FFFF_8000_0000;
            5:       return 64'($urandom_range(0, 40));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        reset            = 1'b1;
        io_Exu_DivValid  = 1'b0;
        io_Exu_Flush     = 1'b0;
        io_Exu_Divw      = 1'b0;
        io_Exu_DivSigned = 1'b0;
        io_Exu_Dividend  = 64'd0;
        io_Exu_Divisor   = 64'd0;
        repeat (3) @(negedge clock);
        chk("reset ready", {63'd0, io_Exu_DivReady}, 64'd1);
        chk("reset outvalid", {63'd0, io_Exu_OutValid}, 64'd0);
        chk("reset quotient", io_Exu_Quotient, 64'd0);
        chk("reset remainder", io_Exu_Remainder, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run(1'b0, 1'b0, 64'd100, 64'd7, "divu_100_7");
        run(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_m7_2");
        run(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "divw_ovf");
        run(1'b0, 1'b0, 64'd5, 64'd0, "divu_by0");
        run(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf64");
        run(1'b1, 1'b0, 64'h1234_5678_FFFF_FFF0, 64'hDEAD_0000_0000_0003, "divuw_big");
        run(1'b1, 1'b1, 64'd77, 64'd0, "divw_by0");

        // Flush ten cycles into Busy: nothing comes out, previous result stays
        issue(1'b0, 1'b0, 64'd1000, 64'd9, 1'b0, "flushed");
        repeat (10) @(negedge clock);
        io_Exu_Flush = 1'b1;
        @(negedge clock);
        io_Exu_Flush = 1'b0;
        chk("flush ready", {63'd0, io_Exu_DivReady}, 64'd1);
        chk("flush outvalid", {63'd0, io_Exu_OutValid}, 64'd0);
        chk("flush quotient", io_Exu_Quotient, last_q);
        chk("flush remainder", io_Exu_Remainder, last_r);
        $display("txn flush checked at cycle %0d", cyc);
        repeat (70) @(negedge clock);
        run(1'b0, 1'b0, 64'd9, 64'd3, "divu_9_3");

        // Reset at Busy cycle 20 clears everything
        issue(1'b0, 1'b1, 64'd123456789, 64'd321, 1'b0, "reset_abort");
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset ready", {63'd0, io_Exu_DivReady}, 64'd1);
        chk("midreset outvalid", {63'd0, io_Exu_OutValid}, 64'd0);
        chk("midreset quotient", io_Exu_Quotient, 64'd0);
        chk("midreset remainder", io_Exu_Remainder, 64'd0);
        $display("txn midreset checked at cycle %0d", cyc);
        reset  = 1'b0;
        last_q = 64'd0;
        last_r = 64'd0;
        repeat (80) @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            logic        w, s;
            logic [63:0] a, b;
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run(w, s, a, b, $sformatf("rand%0d_w%0d_s%0d", i, w, s));
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
